// File: rtl/led_pkg.sv
// Shared types and reset constants for the multi-channel LED driver.
package led_pkg;

  typedef enum logic [1:0] {
    LED_OFF   = 2'b00,
    LED_ON    = 2'b01,
    LED_BLINK = 2'b10,
    LED_PWM   = 2'b11
  } led_mode_e;

  localparam led_mode_e   LED_MODE_RST = LED_ON;
  localparam logic [31:0] LED_DUTY_RST = '0;

endpackage

// File: rtl/led_chan.sv
// One LED channel: mode/duty registers and the combinational output select.
// Duty storage and the PWM compare exist only when LED_PWM_EN is defined.
module led_chan
  import led_pkg::*;
#(
  parameter int unsigned PWM_BITS = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we_i,
  input  logic [1:0]          mode_i,
`ifdef LED_PWM_EN
  input  logic [PWM_BITS-1:0] duty_i,
  input  logic [PWM_BITS-1:0] pwm_cnt_i,
`endif
  input  logic                blink_phase_i,
  output logic                val_o
);

  led_mode_e mode_q;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] duty_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      duty_q <= LED_DUTY_RST[PWM_BITS-1:0];
    end else if (we_i) begin
      duty_q <= duty_i;
    end
  end
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= LED_MODE_RST;
    end else if (we_i) begin
      mode_q <= led_mode_e'(mode_i);
    end
  end

  always_comb begin
    val_o = 1'b0;
    unique case (mode_q)
      LED_OFF:   val_o = 1'b0;
      LED_ON:    val_o = 1'b1;
      LED_BLINK: val_o = blink_phase_i;
`ifdef LED_PWM_EN
      LED_PWM:   val_o = (pwm_cnt_i < duty_q);
`else
      // Without PWM support mode 11 falls back to steady on.
      LED_PWM:   val_o = 1'b1;
`endif
      default:   val_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/led_out_pwm_mc.sv
// Multi-channel LED driver: enable mask, per-channel OFF/ON/BLINK/PWM, registered pins.
// Optional feature: define LED_PWM_EN to build the PWM counter and per-channel duty storage.
module led_out_pwm_mc
  import led_pkg::*;
#(
  parameter int unsigned N_LEDS    = 8,
  parameter int unsigned PWM_BITS  = 4,
  parameter int unsigned BLINK_DIV = 24,
  localparam int unsigned IdxW     = (N_LEDS > 1) ? $clog2(N_LEDS) : 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                led_load,
  input  logic [N_LEDS-1:0]   led_load_data,
  input  logic                cfg_we,
  input  logic [IdxW-1:0]     cfg_idx,
  input  logic [1:0]          cfg_mode,
  input  logic [PWM_BITS-1:0] cfg_duty,
  output logic                blink_phase_o,
  output logic [N_LEDS-1:0]   LED_o
);

  logic [N_LEDS-1:0]    en_q, en_d;
  logic [BLINK_DIV-1:0] blink_cnt_q, blink_cnt_d;
  logic                 phase_q, phase_d;
  logic [N_LEDS-1:0]    led_q, led_d;
  logic [N_LEDS-1:0]    chan_we;
  logic [N_LEDS-1:0]    chan_val;

`ifdef LED_PWM_EN
  logic [PWM_BITS-1:0] pwm_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pwm_cnt_q <= '0;
    end else begin
      pwm_cnt_q <= pwm_cnt_q + PWM_BITS'(1);
    end
  end
`else
  logic unused_cfg_duty;
  assign unused_cfg_duty = ^cfg_duty;
`endif

  always_comb begin
    en_d        = led_load ? led_load_data : en_q;
    blink_cnt_d = blink_cnt_q + BLINK_DIV'(1);
    phase_d     = (&blink_cnt_q) ? ~phase_q : phase_q;
    led_d       = en_q & chan_val;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      en_q        <= '0;
      blink_cnt_q <= '0;
      phase_q     <= 1'b0;
      led_q       <= '0;
    end else begin
      en_q        <= en_d;
      blink_cnt_q <= blink_cnt_d;
      phase_q     <= phase_d;
      led_q       <= led_d;
    end
  end

  // Out-of-range indices match no channel, so such writes are dropped.
  for (genvar i = 0; i < N_LEDS; i++) begin : g_chan
    assign chan_we[i] = cfg_we && (cfg_idx == IdxW'(i));

    led_chan #(
      .PWM_BITS (PWM_BITS)
    ) u_chan (
      .clk           (clk),
      .rst_n         (rst_n),
      .we_i          (chan_we[i]),
      .mode_i        (cfg_mode),
`ifdef LED_PWM_EN
      .duty_i        (cfg_duty),
      .pwm_cnt_i     (pwm_cnt_q),
`endif
      .blink_phase_i (phase_q),
      .val_o         (chan_val[i])
    );
  end

  assign LED_o         = led_q;
  assign blink_phase_o = phase_q;

endmodule

// File: tb/tb_led_out_pwm_mc.sv
// Directed self-checking bench for led_out_pwm_mc (8-channel and 6-channel instances).
module tb_led_out_pwm_mc;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;

  logic       led_load = 1'b0;
  logic [7:0] led_load_data = '0;
  logic       cfg_we = 1'b0;
  logic [2:0] cfg_idx = '0;
  logic [1:0] cfg_mode = '0;
  logic [3:0] cfg_duty = '0;
  logic       blink_phase;
  logic [7:0] led;

  logic       l6_load = 1'b0;
  logic [5:0] l6_data = '0;
  logic       c6_we = 1'b0;
  logic [2:0] c6_idx = '0;
  logic [1:0] c6_mode = '0;
  logic [3:0] c6_duty = '0;
  logic       ph6;
  logic [5:0] led6;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  led_out_pwm_mc #(.N_LEDS(8), .PWM_BITS(4), .BLINK_DIV(3)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .led_load      (led_load),
    .led_load_data (led_load_data),
    .cfg_we        (cfg_we),
    .cfg_idx       (cfg_idx),
    .cfg_mode      (cfg_mode),
    .cfg_duty      (cfg_duty),
    .blink_phase_o (blink_phase),
    .LED_o         (led)
  );

  led_out_pwm_mc #(.N_LEDS(6), .PWM_BITS(4), .BLINK_DIV(3)) dut6 (
    .clk           (clk),
    .rst_n         (rst_n),
    .led_load      (l6_load),
    .led_load_data (l6_data),
    .cfg_we        (c6_we),
    .cfg_idx       (c6_idx),
    .cfg_mode      (c6_mode),
    .cfg_duty      (c6_duty),
    .blink_phase_o (ph6),
    .LED_o         (led6)
  );

  task automatic cfg_write(input int idx, input logic [1:0] m, input logic [3:0] d);
    @(negedge clk);
    cfg_we   = 1'b1;
    cfg_idx  = idx[2:0];
    cfg_mode = m;
    cfg_duty = d;
    @(negedge clk);
    cfg_we   = 1'b0;
  endtask

  task automatic load_en(input logic [7:0] m);
    @(negedge clk);
    led_load      = 1'b1;
    led_load_data = m;
    @(negedge clk);
    led_load      = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    #12;
    checks++;
    if (led !== 8'h00 || blink_phase !== 1'b0) begin
      failures++;
      $display("FAIL reset_state: led=%h phase=%b, required led=00 phase=0", led, blink_phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
    // Prescaler counts 0..7, so the phase flips on the 8th edge after release.
    for (int k = 1; k <= 9; k++) begin
      @(negedge clk);
      checks++;
      if (blink_phase !== (k >= 8)) begin
        failures++;
        $display("FAIL blink_start k=%0d: phase=%b, required %b", k, blink_phase, (k >= 8));
      end
    end
    load_en(8'hFF);
    @(negedge clk);
    checks++;
    if (led !== 8'hFF) begin
      failures++;
      $display("FAIL pre_async_reset: led=%h, required ff", led);
    end
    #2 rst_n = 1'b0;
    #1;
    checks++;
    if (led !== 8'h00 || blink_phase !== 1'b0) begin
      failures++;
      $display("FAIL async_reset: led=%h phase=%b, required led=00 phase=0", led, blink_phase);
    end
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_load();
    @(negedge clk);
    led_load      = 1'b1;
    led_load_data = 8'hA5;
    @(negedge clk);
    led_load = 1'b0;
    checks++;
    if (led !== 8'h00) begin
      failures++;
      $display("FAIL load_latency: led=%h after one edge, required 00", led);
    end
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      checks++;
      if (led !== 8'hA5) begin
        failures++;
        $display("FAIL load_a5 k=%0d: led=%h, required a5", k, led);
      end
    end
  endtask

  task automatic count_pwm(input logic [3:0] duty, input int want, input string name);
    int ones;
    cfg_write(0, 2'b11, duty);
    @(negedge clk);
    ones = 0;
    for (int k = 0; k < 16; k++) begin
      ones += int'(led[0]);
      @(negedge clk);
    end
    checks++;
    if (ones !== want) begin
      failures++;
      $display("FAIL %s: high %0d of 16 cycles, required %0d", name, ones, want);
    end
  endtask

  task automatic test_pwm();
    load_en(8'h01);
`ifdef LED_PWM_EN
    count_pwm(4'd4, 4, "pwm_duty4");
    count_pwm(4'd0, 0, "pwm_duty0");
    count_pwm(4'd15, 15, "pwm_duty15");
    count_pwm(4'd9, 9, "pwm_duty9");
`else
    count_pwm(4'd0, 16, "mode11_as_on_duty0");
    count_pwm(4'd4, 16, "mode11_as_on_duty4");
`endif
  endtask

  task automatic test_blink();
    logic prev;
    int   run;
    int   changes;
    for (int i = 0; i < 8; i++) cfg_write(i, (i == 3) ? 2'b10 : 2'b00, 4'd0);
    load_en(8'hFF);
    @(negedge clk);
    prev    = blink_phase;
    run     = 0;
    changes = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      checks++;
      if (led !== (prev ? 8'h08 : 8'h00)) begin
        failures++;
        $display("FAIL blink_lag k=%0d: led=%h, required %h", k, led, prev ? 8'h08 : 8'h00);
      end
      if (blink_phase !== prev) begin
        if (changes > 0) begin
          checks++;
          if (run !== 8) begin
            failures++;
            $display("FAIL blink_half_period: run=%0d, required 8", run);
          end
        end
        changes++;
        run = 1;
      end else begin
        run++;
      end
      prev = blink_phase;
    end
    checks++;
    if (changes < 4) begin
      failures++;
      $display("FAIL blink_toggles: %0d phase changes in 40 cycles, required >= 4", changes);
    end
  endtask

  task automatic test_back_to_back();
    for (int i = 0; i < 8; i++) cfg_write(i, 2'b01, 4'd0);
    @(negedge clk);
    cfg_we        = 1'b1;
    cfg_idx       = 3'd0;
    cfg_mode      = 2'b00;
    led_load      = 1'b1;
    led_load_data = 8'h7F;
    @(negedge clk);
    cfg_we   = 1'b0;
    led_load = 1'b0;
    @(negedge clk);
    checks++;
    if (led !== 8'h7E) begin
      failures++;
      $display("FAIL cfg_and_load_same_cycle: led=%h, required 7e", led);
    end
  endtask

  task automatic test_idx_range();
    @(negedge clk);
    c6_we   = 1'b1;
    c6_idx  = 3'd7;
    c6_mode = 2'b00;
    l6_load = 1'b1;
    l6_data = 6'h3F;
    @(negedge clk);
    c6_we   = 1'b0;
    l6_load = 1'b0;
    checks++;
    if (led6 !== 6'h00) begin
      failures++;
      $display("FAIL idx_range_latency: led6=%h, required 00", led6);
    end
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if (led6 !== 6'h3F) begin
        failures++;
        $display("FAIL idx_range_ignored k=%0d: led6=%h, required 3f", k, led6);
      end
    end
    @(negedge clk);
    c6_we   = 1'b1;
    c6_idx  = 3'd5;
    c6_mode = 2'b00;
    @(negedge clk);
    c6_we = 1'b0;
    @(negedge clk);
    checks++;
    if (led6 !== 6'h1F) begin
      failures++;
      $display("FAIL idx_in_range: led6=%h, required 1f", led6);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_pwm();
    test_blink();
    test_back_to_back();
    test_idx_range();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
